layer_2_pool_ctrl: RTL and testbench

Streaming 2x2/stride-2 average-pool sequencer for layer 2. It accepts layer-2 conv output one pixel per beat in raster order, with 8 channels x 16 bit per pixel. It buffers the even row, pairs adjacent columns, and packs each 2x2 window into the eight 64-bit channel groups consumed by the existing Layer_2_pool datapath. The pooled 8x16-bit result is registered and presented downstream over a valid/ready handshake.

---
 rtl/layer2_pkg.sv | 37 +++
 rtl/Layer_2_pool.sv | 16 +
 rtl/layer_2_pool_ctrl.sv | 150 +++++++++++++++
 tb/tb_layer_2_pool_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer2_pkg.sv
// Shared constants, FSM state type and window arithmetic for the layer-2
// pooling path.
package layer2_pkg;

  localparam int L2_CH    = 8;
  localparam int L2_DW    = 16;
  localparam int L2_PIX_W = L2_CH * L2_DW;
  localparam int L2_GRP_W = 4 * L2_DW;

  typedef enum logic [0:0] {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } l2_state_e;

  // Rounded mean of one channel group {BR, BL, TR, TL}; the 16-bit sum wraps.
  function automatic logic [L2_DW-1:0] l2_avg4(input logic [L2_GRP_W-1:0] grp);
    logic [L2_DW-1:0] sum;
    sum = grp[0*L2_DW +: L2_DW] + grp[1*L2_DW +: L2_DW]
        + grp[2*L2_DW +: L2_DW] + grp[3*L2_DW +: L2_DW] + 16'd2;
    return sum >> 2;
  endfunction

  function automatic logic [L2_CH*L2_GRP_W-1:0] l2_pack_window(
    input logic [L2_PIX_W-1:0] tl,
    input logic [L2_PIX_W-1:0] tr,
    input logic [L2_PIX_W-1:0] bl,
    input logic [L2_PIX_W-1:0] br
  );
    logic [L2_CH*L2_GRP_W-1:0] grps;
    for (int c = 0; c < L2_CH; c++) begin
      grps[c*L2_GRP_W +: L2_GRP_W] = {br[c*L2_DW +: L2_DW], bl[c*L2_DW +: L2_DW],
                                      tr[c*L2_DW +: L2_DW], tl[c*L2_DW +: L2_DW]};
    end
    return grps;
  endfunction

endpackage

// File: rtl/Layer_2_pool.sv
// Combinational 2x2 average over eight packed 64-bit channel groups.
module Layer_2_pool
  import layer2_pkg::*;
(
  input  logic [L2_CH*L2_GRP_W-1:0] i_grp,
  output logic [L2_PIX_W-1:0]       o_pix
);

  always_comb begin
    o_pix = '0;
    for (int c = 0; c < L2_CH; c++) begin
      o_pix[c*L2_DW +: L2_DW] = l2_avg4(i_grp[c*L2_GRP_W +: L2_GRP_W]);
    end
  end

endmodule

// File: rtl/layer_2_pool_ctrl.sv
// Streaming 2x2/stride-2 average-pool sequencer: buffers the even row, pairs
// columns on the odd row and registers one pooled pixel per window.
//
// state    | meaning
// ROW_EVEN | even input row, beats written to the line buffer
// ROW_ODD  | odd input row, even col loads hold reg, odd col fires a window
module layer_2_pool_ctrl
  import layer2_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CH    = L2_CH,
  parameter int DW    = L2_DW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [CH*DW-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CH*DW-1:0] o_data,
  output logic             o_last,
  output logic             o_busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = CH * DW;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  l2_state_e     state_q, state_d;
  logic [PW-1:0] hold_q, hold_d;
  logic [PW-1:0] linebuf_q [IMG_W];
  logic [PW-1:0] linebuf_d [IMG_W];
  logic          o_valid_q, o_valid_d;
  logic [PW-1:0] o_data_q, o_data_d;
  logic          o_last_q, o_last_d;
  logic          o_busy_q, o_busy_d;

  logic                      acc;
  logic                      fire;
  logic                      col_last;
  logic                      row_last;
  logic [CW-1:0]             col_even;
  logic [CH*L2_GRP_W-1:0]    win_grp;
  logic [PW-1:0]             pool_pix;

  // Ready depends only on registered state and i_ready, never on i_valid.
  assign o_ready  = ~o_valid_q | i_ready;
  assign acc      = i_valid & o_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign col_even = col_q & ~COL_ONE;
  assign fire     = acc & (state_q == ROW_ODD) & col_q[0];

  assign win_grp = l2_pack_window(linebuf_q[col_even], linebuf_q[col_q], hold_q, i_data);

  Layer_2_pool u_pool (
    .i_grp (win_grp),
    .o_pix (pool_pix)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    hold_d  = hold_q;
    if (acc) begin
      if (state_q == ROW_ODD && !col_q[0]) begin
        hold_d = i_data;
      end
      if (col_last) begin
        col_d   = '0;
        state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        row_d   = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    linebuf_d = linebuf_q;
    if (acc && state_q == ROW_EVEN) begin
      linebuf_d[col_q] = i_data;
    end
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    if (fire) begin
      o_valid_d = 1'b1;
      o_data_d  = pool_pix;
      o_last_d  = row_last & col_last;
    end else if (i_ready) begin
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end
  end

  // A new frame's first beat may land in the same cycle the last pixel leaves.
  always_comb begin
    o_busy_d = o_busy_q;
    if (o_valid_q && i_ready && o_last_q) begin
      o_busy_d = 1'b0;
    end
    if (acc) begin
      o_busy_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      state_q   <= ROW_EVEN;
      hold_q    <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_busy_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_busy_q  <= o_busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    linebuf_q <= linebuf_d;
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign o_busy  = o_busy_q;

endmodule

// File: tb/tb_layer_2_pool_ctrl.sv
// Self-checking bench for layer_2_pool_ctrl: window table, channel placement,
// backpressure, random frames against a frame-level model, and mid-frame reset.
module tb_layer_2_pool_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NP = W * H;
  localparam int NO = (W / 2) * (H / 2);

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;
  logic         o_last;
  logic         o_busy;

  layer_2_pool_ctrl #(.IMG_W(W), .IMG_H(H), .CH(8), .DW(16)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    logic [15:0] tl;
    logic [15:0] tr;
    logic [15:0] bl;
    logic [15:0] br;
    logic [15:0] avg;
  } vec_t;

  int           total = 0;
  int           bad = 0;
  int           ready_pct = 100;
  int           gap_pct = 0;
  int           pix_sent = 0;
  int           out_cnt = 0;
  exp_t         exp_q[$];
  logic [127:0] frm [NP];
  vec_t         tbl [NO];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge i_clk) i_ready = ($urandom_range(99) < ready_pct);

  always @(negedge i_clk) begin
    #2;
    if (i_rst_n) begin
      if (prev_stall) begin
        chk("stall_hold_valid", 128'(o_valid), 128'(1));
        chk("stall_hold_data", o_data, prev_data);
      end
      if (o_valid && !i_ready) chk("stall_o_ready", 128'(o_ready), 128'(0));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", o_data, e.data);
          chk("out_last", 128'(o_last), 128'(e.last));
        end
        out_cnt++;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Expected pooled stream of the whole frame in frm, from the averaging rule.
  task automatic model_push();
    for (int wr = 0; wr < H / 2; wr++) begin
      for (int wc = 0; wc < W / 2; wc++) begin
        exp_t e;
        int   b;
        b = 2 * wr * W + 2 * wc;
        e.data = '0;
        for (int ch = 0; ch < 8; ch++) begin
          int s;
          s = int'(frm[b][16*ch +: 16]) + int'(frm[b+1][16*ch +: 16])
            + int'(frm[b+W][16*ch +: 16]) + int'(frm[b+W+1][16*ch +: 16]) + 2;
          e.data[16*ch +: 16] = 16'((s % 65536) / 4);
        end
        e.last = (wr == H / 2 - 1) && (wc == W / 2 - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_pix(input logic [127:0] d);
    int   budget;
    logic ok;
    budget = 0;
    while ($urandom_range(99) < gap_pct) begin
      i_valid = 1'b0;
      i_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge i_clk);
    end
    i_valid = 1'b1;
    i_data  = d;
    forever begin
      #1;
      ok = o_ready;
      @(negedge i_clk);
      if (ok) break;
      budget++;
      if (budget > 2000) begin
        chk("accept_timeout", 128'(0), 128'(1));
        break;
      end
    end
    i_valid = 1'b0;
    i_data  = {$urandom, $urandom, $urandom, $urandom};
    pix_sent++;
  endtask

  task automatic send_frame();
    pix_sent = 0;
    for (int i = 0; i < NP; i++) send_pix(frm[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_pct = 100;
    while ((exp_q.size() != 0 || o_valid) && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 128'(0), 128'(1));
  endtask

  task automatic random_frame();
    for (int i = 0; i < NP; i++) frm[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_pix(input int n);
    int t;
    t = 0;
    while (pix_sent < n && t < 5000) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 5000) chk("pix_wait_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    tbl[0]  = '{16'd1,     16'd1,   16'd1,   16'd2,   16'd1};
    tbl[1]  = '{16'd1,     16'd1,   16'd2,   16'd2,   16'd2};
    tbl[2]  = '{16'hFFFF,  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3FFF};
    tbl[3]  = '{16'h0010,  16'h0010, 16'h0010, 16'h0010, 16'h0010};
    tbl[4]  = '{16'd0,     16'd0,   16'd0,   16'd1,   16'd0};
    tbl[5]  = '{16'd0,     16'd0,   16'd1,   16'd1,   16'd1};
    tbl[6]  = '{16'd3,     16'd3,   16'd3,   16'd3,   16'd3};
    tbl[7]  = '{16'd0,     16'd0,   16'd0,   16'd0,   16'd0};
    tbl[8]  = '{16'd100,   16'd200, 16'd300, 16'd400, 16'd250};
    tbl[9]  = '{16'h4000,  16'h4000, 16'h4000, 16'h4000, 16'h0000};
    tbl[10] = '{16'h8000,  16'd0,   16'd0,   16'd0,   16'h2000};
    tbl[11] = '{16'd7,     16'd7,   16'd7,   16'd7,   16'd7};
    tbl[12] = '{16'hFFFE,  16'd0,   16'd0,   16'd0,   16'h0000};
    tbl[13] = '{16'hFFFD,  16'd0,   16'd0,   16'd0,   16'h3FFF};
    tbl[14] = '{16'd5,     16'd6,   16'd7,   16'd8,   16'd7};
    tbl[15] = '{16'd2,     16'd2,   16'd2,   16'd3,   16'd2};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_o_valid", 128'(o_valid), 128'(0));
    chk("rst_o_data", o_data, 128'(0));
    chk("rst_o_last", 128'(o_last), 128'(0));
    chk("rst_o_busy", 128'(o_busy), 128'(0));
    chk("rst_o_ready", 128'(o_ready), 128'(1));
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // constant frame
    for (int i = 0; i < NP; i++) frm[i] = {8{16'h0010}};
    model_push();
    out_cnt = 0;
    send_frame();
    chk("const_busy_mid", 128'(o_busy), 128'(1));
    drain();
    chk("const_count", 128'(out_cnt), 128'(NO));
    chk("const_busy_end", 128'(o_busy), 128'(0));

    // channel placement and first-output latency
    for (int i = 0; i < NP; i++)
      for (int ch = 0; ch < 8; ch++) frm[i][16*ch +: 16] = 16'(ch + 1);
    model_push();
    out_cnt = 0;
    pix_sent = 0;
    for (int i = 0; i <= W; i++) send_pix(frm[i]);
    chk("place_not_early", 128'(o_valid), 128'(0));
    send_pix(frm[W + 1]);
    chk("place_latency", 128'(o_valid), 128'(1));
    chk("place_data", o_data, {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
    for (int i = W + 2; i < NP; i++) send_pix(frm[i]);
    drain();
    chk("place_count", 128'(out_cnt), 128'(NO));

    // window table, values replicated on every channel
    for (int k = 0; k < NO; k++) begin
      int   b;
      exp_t e;
      b = 2 * (k / (W / 2)) * W + 2 * (k % (W / 2));
      frm[b]       = {8{tbl[k].tl}};
      frm[b+1]     = {8{tbl[k].tr}};
      frm[b+W]     = {8{tbl[k].bl}};
      frm[b+W+1]   = {8{tbl[k].br}};
      e.data = {8{tbl[k].avg}};
      e.last = (k == NO - 1);
      exp_q.push_back(e);
    end
    out_cnt = 0;
    ready_pct = 50;
    gap_pct = 20;
    send_frame();
    drain();
    chk("table_count", 128'(out_cnt), 128'(NO));
    gap_pct = 0;

    // 20-cycle stall during row 3
    random_frame();
    model_push();
    out_cnt = 0;
    fork
      send_frame();
      begin
        wait_pix(3 * W);
        ready_pct = 0;
        repeat (20) @(negedge i_clk);
        ready_pct = 100;
      end
    join
    drain();
    chk("stall_count", 128'(out_cnt), 128'(NO));

    // back-to-back random frames with random gaps and backpressure
    out_cnt = 0;
    ready_pct = 60;
    gap_pct = 30;
    for (int f = 0; f < 3; f++) begin
      random_frame();
      model_push();
      send_frame();
    end
    drain();
    chk("rand_count", 128'(out_cnt), 128'(3 * NO));
    chk("rand_busy_end", 128'(o_busy), 128'(0));
    gap_pct = 0;

    // asynchronous reset mid row 5
    random_frame();
    model_push();
    ready_pct = 70;
    fork
      send_frame();
      begin
        wait_pix(5 * W + 3);
        #3;
        i_rst_n = 1'b0;
      end
    join_any
    disable fork;
    i_valid = 1'b0;
    #1;
    chk("mid_rst_o_valid", 128'(o_valid), 128'(0));
    chk("mid_rst_o_data", o_data, 128'(0));
    chk("mid_rst_o_busy", 128'(o_busy), 128'(0));
    exp_q.delete();
    ready_pct = 100;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    random_frame();
    model_push();
    out_cnt = 0;
    ready_pct = 80;
    send_frame();
    drain();
    chk("post_rst_count", 128'(out_cnt), 128'(NO));
    chk("post_rst_busy", 128'(o_busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
